// File: rtl/hack_alu_seq_pkg.sv
// Shared definitions for the sequential Hack ALU: FSM states and the
// Hack control encodings ({zx,nx,zy,ny,f,no}).
package hack_alu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [5:0] ALU_ZERO    = 6'b101010;
  localparam logic [5:0] ALU_ONE     = 6'b111111;
  localparam logic [5:0] ALU_MINUS1  = 6'b111010;
  localparam logic [5:0] ALU_X       = 6'b001100;
  localparam logic [5:0] ALU_Y       = 6'b110000;
  localparam logic [5:0] ALU_NOTX    = 6'b001101;
  localparam logic [5:0] ALU_XPLUSY  = 6'b000010;
  localparam logic [5:0] ALU_XMINUSY = 6'b010011;
  localparam logic [5:0] ALU_YMINUSX = 6'b000111;
  localparam logic [5:0] ALU_XANDY   = 6'b000000;
  localparam logic [5:0] ALU_XORY    = 6'b010101;

endpackage

// File: rtl/hack_alu_seq_comb.sv
// Combinational Hack ALU of arbitrary width, with zero/negative flags.
module hack_alu_comb #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_zx,
  input  logic             i_nx,
  input  logic             i_zy,
  input  logic             i_ny,
  input  logic             i_f,
  input  logic             i_no,
  output logic [WIDTH-1:0] o_out,
  output logic             o_zr,
  output logic             o_ng
);

  logic [WIDTH-1:0] w_x0, w_x1, w_y0, w_y1, w_fn;

  // Operand conditioning, function select, output negate, flags
  always_comb begin
    w_x0  = i_zx ? '0 : i_x;
    w_x1  = i_nx ? ~w_x0 : w_x0;
    w_y0  = i_zy ? '0 : i_y;
    w_y1  = i_ny ? ~w_y0 : w_y0;
    w_fn  = i_f ? (w_x1 + w_y1) : (w_x1 & w_y1);
    o_out = i_no ? ~w_fn : w_fn;
    o_zr  = (o_out == '0);
    o_ng  = o_out[WIDTH-1];
  end

endmodule

// File: rtl/hack_alu_seq.sv
// Sequential Hack ALU: one op per valid/ready handshake, registered result
// and flags, plus an optional unsigned shift-add multiply (one bit/cycle).
module hack_alu_seq
  import hack_alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  input  logic             mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t               r_state, w_state_nxt;
  logic [WIDTH-1:0]     r_out, r_mplier;
  logic                 r_zr, r_ng, r_ovf;
  logic [2*WIDTH-1:0]   r_acc, r_mcand;
  logic [CW-1:0]        r_cnt;

  logic [WIDTH-1:0]     w_hack_out;
  logic                 w_hack_zr, w_hack_ng;
  logic                 w_accept, w_is_mul, w_last;
  logic [2*WIDTH-1:0]   w_acc_step;
  logic [WIDTH-1:0]     w_prod_lo;

  hack_alu_comb #(.WIDTH(WIDTH)) u_comb (
    .i_x  (x),
    .i_y  (y),
    .i_zx (zx),
    .i_nx (nx),
    .i_zy (zy),
    .i_ny (ny),
    .i_f  (f),
    .i_no (no),
    .o_out(w_hack_out),
    .o_zr (w_hack_zr),
    .o_ng (w_hack_ng)
  );

  assign w_is_mul   = mul & MUL_EN;
  assign w_accept   = in_valid & in_ready;
  assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  assign w_prod_lo  = w_acc_step[WIDTH-1:0];

  assign out_valid = (r_state == ST_HOLD);
  assign busy      = (r_state == ST_MUL);
  assign out       = r_out;
  assign zr        = r_zr;
  assign ng        = r_ng;
  assign ovf       = r_ovf;

  // Next-state and handshake ready
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = w_is_mul ? ST_MUL : ST_HOLD;
      end
      ST_MUL: begin
        if (w_last) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) w_state_nxt = w_is_mul ? ST_MUL : ST_HOLD;
          else          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Multiply datapath: capture on accept, one multiplier bit per MUL cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (w_accept && w_is_mul) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, x};
      r_mplier <= y;
      r_cnt    <= '0;
    end else if (r_state == ST_MUL) begin
      r_acc    <= w_acc_step;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  // Result/flag registers, loaded only on entry to HOLD; flags are computed
  // from the same value that is loaded into out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out <= '0;
      r_zr  <= 1'b0;
      r_ng  <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_out <= w_hack_out;
      r_zr  <= w_hack_zr;
      r_ng  <= w_hack_ng;
      r_ovf <= 1'b0;
    end else if (r_state == ST_MUL && w_last) begin
      r_out <= w_prod_lo;
      r_zr  <= (w_prod_lo == '0);
      r_ng  <= w_prod_lo[WIDTH-1];
      r_ovf <= |w_acc_step[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: tb/tb_hack_alu_seq.sv
// Self-checking bench for hack_alu_seq: 16-bit instance plus two 8-bit
// instances (with and without multiply).
module tb_hack_alu_seq;
  import hack_alu_seq_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // 16-bit, MUL_EN=1
  logic        iv = 0, ordy = 0, m = 0;
  logic [5:0]  c = '0;
  logic [15:0] x = '0, y = '0;
  logic        ir, ov, zr, ng, ovf, busy;
  logic [15:0] o;

  // 8-bit instances share operands/controls, separate handshakes
  logic        iva = 0, ivb = 0, ora = 0, orb = 0, m8 = 0;
  logic [5:0]  c8 = '0;
  logic [7:0]  x8 = '0, y8 = '0;
  logic        ir_a, ov_a, zr_a, ng_a, ovf_a, busy_a;
  logic        ir_b, ov_b, zr_b, ng_b, ovf_b, busy_b;
  logic [7:0]  o_a, o_b;

  int tests = 0;
  int fails = 0;

  hack_alu_seq #(.WIDTH(16), .MUL_EN(1'b1)) u16 (
    .clk(clk), .reset(reset), .in_valid(iv), .in_ready(ir), .x(x), .y(y),
    .zx(c[5]), .nx(c[4]), .zy(c[3]), .ny(c[2]), .f(c[1]), .no(c[0]), .mul(m),
    .out_valid(ov), .out_ready(ordy), .out(o), .zr(zr), .ng(ng), .ovf(ovf), .busy(busy));

  hack_alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) u8a (
    .clk(clk), .reset(reset), .in_valid(iva), .in_ready(ir_a), .x(x8), .y(y8),
    .zx(c8[5]), .nx(c8[4]), .zy(c8[3]), .ny(c8[2]), .f(c8[1]), .no(c8[0]), .mul(m8),
    .out_valid(ov_a), .out_ready(ora), .out(o_a), .zr(zr_a), .ng(ng_a), .ovf(ovf_a), .busy(busy_a));

  hack_alu_seq #(.WIDTH(8), .MUL_EN(1'b0)) u8b (
    .clk(clk), .reset(reset), .in_valid(ivb), .in_ready(ir_b), .x(x8), .y(y8),
    .zx(c8[5]), .nx(c8[4]), .zy(c8[3]), .ny(c8[2]), .f(c8[1]), .no(c8[0]), .mul(m8),
    .out_valid(ov_b), .out_ready(orb), .out(o_b), .zr(zr_b), .ng(ng_b), .ovf(ovf_b), .busy(busy_b));

  // Reference Hack function on integers, masked to w bits
  function automatic longint unsigned hack_ref(longint unsigned xa, longint unsigned ya,
                                               logic [5:0] cc, int w);
    longint unsigned mask, a, b, r;
    mask = (64'd1 << w) - 1;
    a = xa & mask;
    b = ya & mask;
    if (cc[5]) a = 0;
    if (cc[4]) a = ~a & mask;
    if (cc[3]) b = 0;
    if (cc[2]) b = ~b & mask;
    r = cc[1] ? ((a + b) & mask) : (a & b);
    if (cc[0]) r = ~r & mask;
    return r;
  endfunction

  // Present one op to u16 while it is idle; count cycles to out_valid
  task automatic issue16(input logic [15:0] xi, input logic [15:0] yi, input logic [5:0] ci,
                         input logic mi, output int lat, output int bcnt);
    x = xi; y = yi; c = ci; m = mi; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    lat = 1; bcnt = 0;
    while (!ov && lat < 64) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release16();
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    tests++; if (ov !== 1'b0)    begin fails++; $display("FAIL reset_out_valid got=%b exp=0", ov); end
    tests++; if (o !== 16'h0)    begin fails++; $display("FAIL reset_out got=%h exp=0000", o); end
    tests++; if ({zr, ng, ovf, busy} !== 4'b0) begin fails++; $display("FAIL reset_flags got=%b exp=0000", {zr, ng, ovf, busy}); end
    tests++; if (ir !== 1'b1)    begin fails++; $display("FAIL reset_in_ready got=%b exp=1", ir); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_hack_directed();
    logic [15:0] xs [4] = '{16'd4, 16'd4, 16'd4, 16'd4};
    logic [15:0] ys [4] = '{16'd1, 16'd1, 16'd1, 16'd1};
    logic [5:0]  cs [4] = '{ALU_XPLUSY, ALU_YMINUSX, ALU_ZERO, ALU_XMINUSY};
    logic [15:0] ex [4] = '{16'd5, 16'hFFFD, 16'd0, 16'd3};
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      issue16(xs[i], ys[i], cs[i], 1'b0, lat, bc);
      tests++; if (lat !== 1) begin fails++; $display("FAIL hack_dir_latency[%0d] got=%0d exp=1", i, lat); end
      tests++; if (o !== ex[i]) begin fails++; $display("FAIL hack_dir_out[%0d] got=%h exp=%h", i, o, ex[i]); end
      tests++; if ({zr, ng, ovf} !== {ex[i] == 16'd0, ex[i][15], 1'b0})
        begin fails++; $display("FAIL hack_dir_flags[%0d] got=%b exp=%b", i, {zr, ng, ovf}, {ex[i] == 16'd0, ex[i][15], 1'b0}); end
      release16();
    end
  endtask

  task automatic test_hack_random();
    logic [5:0] ctab [11] = '{ALU_ZERO, ALU_ONE, ALU_MINUS1, ALU_X, ALU_Y, ALU_NOTX,
                              ALU_XPLUSY, ALU_XMINUSY, ALU_YMINUSX, ALU_XANDY, ALU_XORY};
    logic [15:0] xi, yi, exp;
    logic [5:0] ci;
    int lat, bc;
    for (int i = 0; i < 24; i++) begin
      xi = 16'($urandom);
      yi = 16'($urandom);
      ci = (i % 2 == 0) ? ctab[$urandom_range(0, 10)] : 6'($urandom);
      exp = 16'(hack_ref(64'(xi), 64'(yi), ci, 16));
      issue16(xi, yi, ci, 1'b0, lat, bc);
      tests++; if (lat !== 1 || o !== exp || zr !== (exp == 16'd0) || ng !== exp[15] || ovf !== 1'b0)
        begin fails++; $display("FAIL hack_rand[%0d] x=%h y=%h c=%b got=%h/%b%b%b lat=%0d exp=%h/%b%b0 lat=1",
                                i, xi, yi, ci, o, zr, ng, ovf, lat, exp, exp == 16'd0, exp[15]); end
      release16();
    end
  endtask

  task automatic test_mul();
    logic [15:0] xs [8];
    logic [15:0] ys [8];
    longint unsigned p;
    logic [15:0] lo;
    int lat, bc;
    xs[0] = 16'd7;   ys[0] = 16'd6;
    xs[1] = 16'd300; ys[1] = 16'd300;
    xs[2] = 16'hFFFF; ys[2] = 16'hFFFF;
    xs[3] = 16'd0;   ys[3] = 16'h1234;
    for (int i = 4; i < 8; i++) begin xs[i] = 16'($urandom); ys[i] = 16'($urandom); end
    for (int i = 0; i < 8; i++) begin
      p  = 64'(xs[i]) * 64'(ys[i]);
      lo = p[15:0];
      issue16(xs[i], ys[i], 6'($urandom), 1'b1, lat, bc);
      tests++; if (lat !== 17) begin fails++; $display("FAIL mul_latency[%0d] got=%0d exp=17", i, lat); end
      tests++; if (bc !== 16)  begin fails++; $display("FAIL mul_busy_cycles[%0d] got=%0d exp=16", i, bc); end
      tests++; if (o !== lo || ovf !== (p[31:16] != 16'd0) || zr !== (lo == 16'd0) || ng !== lo[15])
        begin fails++; $display("FAIL mul_result[%0d] %0d*%0d got=%h ovf=%b zr=%b ng=%b exp=%h ovf=%b",
                                i, xs[i], ys[i], o, ovf, zr, ng, lo, p[31:16] != 16'd0); end
      release16();
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic [15:0] held;
    issue16(16'd100, 16'd23, ALU_XMINUSY, 1'b0, lat, bc);
    held = o;
    tests++; if (held !== 16'd77) begin fails++; $display("FAIL bp_first got=%h exp=004d", held); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      tests++; if (o !== 16'd77 || ov !== 1'b1 || ir !== 1'b0 || zr !== 1'b0 || ng !== 1'b0)
        begin fails++; $display("FAIL bp_stall[%0d] out=%h ov=%b ir=%b got flags=%b%b exp out=004d ov=1 ir=0", k, o, ov, ir, zr, ng); end
    end
    // Hack op accepted straight out of HOLD
    x = 16'd9; y = 16'd9; c = ALU_XMINUSY; m = 1'b0; iv = 1'b1; ordy = 1'b1;
    #1;
    tests++; if (ir !== 1'b1) begin fails++; $display("FAIL b2b_in_ready got=%b exp=1", ir); end
    @(posedge clk); #1;
    tests++; if (ov !== 1'b1 || o !== 16'd0 || zr !== 1'b1)
      begin fails++; $display("FAIL b2b_hack got ov=%b out=%h zr=%b exp ov=1 out=0000 zr=1", ov, o, zr); end
    // Multiply accepted straight out of HOLD
    x = 16'd1000; y = 16'd1000; m = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0; ordy = 1'b0;
    lat = 1;
    while (!ov && lat < 64) begin @(posedge clk); #1; lat++; end
    tests++; if (lat !== 17 || o !== 16'h4240 || ovf !== 1'b1)
      begin fails++; $display("FAIL b2b_mul got lat=%0d out=%h ovf=%b exp lat=17 out=4240 ovf=1", lat, o, ovf); end
    release16();
    tests++; if (ov !== 1'b0 || ir !== 1'b1) begin fails++; $display("FAIL b2b_idle got ov=%b ir=%b exp 0 1", ov, ir); end
  endtask

  task automatic test_reset_mid_mul();
    int lat, bc;
    x = 16'd300; y = 16'd300; m = 1'b1; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL midmul_busy got=%b exp=1", busy); end
    reset = 1'b1;
    #1;
    tests++; if (ov !== 1'b0 || o !== 16'd0 || busy !== 1'b0 || ir !== 1'b1 || ovf !== 1'b0 || zr !== 1'b0)
      begin fails++; $display("FAIL midmul_reset got ov=%b out=%h busy=%b ir=%b ovf=%b zr=%b exp 0 0000 0 1 0 0", ov, o, busy, ir, ovf, zr); end
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    tests++; if (ov !== 1'b0) begin fails++; $display("FAIL midmul_no_output got=%b exp=0", ov); end
    issue16(16'd12, 16'd11, 6'd0, 1'b1, lat, bc);
    tests++; if (lat !== 17 || o !== 16'd132 || ovf !== 1'b0)
      begin fails++; $display("FAIL midmul_after got lat=%0d out=%0d ovf=%b exp lat=17 out=132 ovf=0", lat, o, ovf); end
    release16();
  endtask

  task automatic test_width8();
    int lat;
    // 0x7F + 1 on the 8-bit multiply instance
    x8 = 8'h7F; y8 = 8'h01; c8 = ALU_XPLUSY; m8 = 1'b0; iva = 1'b1;
    @(posedge clk); #1; iva = 1'b0;
    tests++; if (ov_a !== 1'b1 || o_a !== 8'h80 || ng_a !== 1'b1 || zr_a !== 1'b0)
      begin fails++; $display("FAIL w8_add got ov=%b out=%h ng=%b zr=%b exp 1 80 1 0", ov_a, o_a, ng_a, zr_a); end
    ora = 1'b1; @(posedge clk); #1; ora = 1'b0;
    // 16*16 = 256 wraps to zero in 8 bits
    x8 = 8'd16; y8 = 8'd16; m8 = 1'b1; iva = 1'b1;
    @(posedge clk); #1; iva = 1'b0;
    lat = 1;
    while (!ov_a && lat < 64) begin @(posedge clk); #1; lat++; end
    tests++; if (lat !== 9 || o_a !== 8'h00 || zr_a !== 1'b1 || ovf_a !== 1'b1)
      begin fails++; $display("FAIL w8_mul got lat=%0d out=%h zr=%b ovf=%b exp lat=9 out=00 zr=1 ovf=1", lat, o_a, zr_a, ovf_a); end
    ora = 1'b1; @(posedge clk); #1; ora = 1'b0;
    // MUL_EN=0: mul is ignored, plain Hack add with 1-cycle latency
    x8 = 8'd3; y8 = 8'd4; c8 = ALU_XPLUSY; m8 = 1'b1; ivb = 1'b1;
    @(posedge clk); #1; ivb = 1'b0;
    tests++; if (ov_b !== 1'b1 || busy_b !== 1'b0 || o_b !== 8'd7 || ovf_b !== 1'b0)
      begin fails++; $display("FAIL w8_nomul got ov=%b busy=%b out=%0d ovf=%b exp 1 0 7 0", ov_b, busy_b, o_b, ovf_b); end
    orb = 1'b1; @(posedge clk); #1; orb = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hack_directed();
    test_hack_random();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    test_width8();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
